// File: rtl/layer_sequencer.sv
// layer_sequencer: runs cfg_num_layers layers on top_system (clear, start, wait busy/idle),
//   captures flagged acc lanes during each layer and drains them to the output BRAM.
// Latency: per layer 3 + t_wait + t_run + N_MACS cycles; all outputs registered.
// Backpressure: none; BRAM writes are unconditional, one per DRAIN cycle; a stalled
//   start is bounded by START_TIMEOUT.
// Ports: clk/rst (sync, active-high); go + cfg_* run request; sys_* handshake to
//   top_system; out_bram_* write port; busy/done/error/layer_idx status.
module layer_sequencer #(
  parameter int ACC_W         = 16,
  parameter int N_MACS        = 4,
  parameter int MEM_DEPTH     = 256,
  parameter int MAX_LAYERS    = 16,
  parameter int START_TIMEOUT = 64,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int LW = $clog2(MAX_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [LW-1:0]           cfg_num_layers,
  input  logic [AW-1:0]           cfg_out_base,
  output logic                    sys_start,
  output logic                    sys_clear,
  input  logic                    sys_busy,
  input  logic [N_MACS*ACC_W-1:0] sys_acc,
  input  logic [N_MACS-1:0]       sys_valid,
  output logic [AW-1:0]           out_bram_addr,
  output logic                    out_bram_we,
  output logic [ACC_W-1:0]        out_bram_din,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [LW-1:0]           layer_idx
);

  localparam int JW = (N_MACS > 1) ? $clog2(N_MACS) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAYER_CHK, S_CLEAR, S_START, S_WAIT_BUSY, S_RUN, S_DRAIN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     num_q, num_d;
  logic [LW-1:0]     layer_q, layer_d;
  logic [AW-1:0]     base_q, base_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [JW-1:0]     j_q, j_d;
  logic [ACC_W-1:0]  cap_q [N_MACS];
  logic [ACC_W-1:0]  cap_d [N_MACS];
  logic [N_MACS-1:0] capv_q, capv_d;
  logic              error_q, error_d;

  logic              start_q, clear_q, we_q, busy_q, done_q;
  logic [AW-1:0]     addr_q, addr_d;
  logic [ACC_W-1:0]  din_q, din_d;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    layer_d = layer_q;
    base_d  = base_q;
    tmo_d   = tmo_q;
    j_d     = j_q;
    cap_d   = cap_q;
    capv_d  = capv_q;
    error_d = error_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          num_d   = cfg_num_layers;
          base_d  = cfg_out_base;
          layer_d = '0;
          error_d = 1'b0;
          state_d = S_LAYER_CHK;
        end
      end
      S_LAYER_CHK: state_d = (layer_q == num_q) ? S_DONE : S_CLEAR;
      S_CLEAR: begin
        capv_d = '0;
        for (int i = 0; i < N_MACS; i++) cap_d[i] = '0;
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (sys_busy) begin
          state_d = S_RUN;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(START_TIMEOUT)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Capture also applies on the cycle busy drops: the last valid_out can
        // coincide with the busy falling edge.
        for (int i = 0; i < N_MACS; i++) begin
          if (sys_valid[i]) begin
            cap_d[i]  = sys_acc[i*ACC_W +: ACC_W];
            capv_d[i] = 1'b1;
          end
        end
        if (!sys_busy) begin
          j_d     = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (j_q == JW'(N_MACS - 1)) begin
          layer_d = layer_q + 1'b1;
          state_d = S_LAYER_CHK;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded from next-state values so each strobe lines
    // up with the state it belongs to.
    addr_d = '0;
    din_d  = '0;
    if (state_d == S_DRAIN) begin
      addr_d = base_q + AW'(layer_q * N_MACS) + AW'(j_d);
      din_d  = capv_d[j_d] ? cap_d[j_d] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      layer_q <= '0;
      base_q  <= '0;
      tmo_q   <= '0;
      j_q     <= '0;
      capv_q  <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < N_MACS; i++) cap_q[i] <= '0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      layer_q <= layer_d;
      base_q  <= base_d;
      tmo_q   <= tmo_d;
      j_q     <= j_d;
      capv_q  <= capv_d;
      error_q <= error_d;
      for (int i = 0; i < N_MACS; i++) cap_q[i] <= cap_d[i];
      start_q <= (state_d == S_START);
      clear_q <= (state_d == S_CLEAR);
      we_q    <= (state_d == S_DRAIN);
      busy_q  <= !((state_d == S_IDLE) || (state_d == S_DONE));
      done_q  <= (state_d == S_DONE);
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign sys_start     = start_q;
  assign sys_clear     = clear_q;
  assign out_bram_we   = we_q;
  assign out_bram_addr = addr_q;
  assign out_bram_din  = din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign layer_idx     = layer_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Testbench for layer_sequencer: table of run records plus hand-written timing,
// zero-layer, timeout and mid-drain reset sequences, against a small top_system model.
module tb_layer_sequencer;

  localparam int ACC_W = 16;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int LW    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic [LW-1:0]     cfg_num_layers = '0;
  logic [AW-1:0]     cfg_out_base = '0;
  logic              sys_start, sys_clear;
  logic              sys_busy = 1'b0;
  logic [N*ACC_W-1:0] sys_acc = '0;
  logic [N-1:0]      sys_valid = '0;
  logic [AW-1:0]     out_bram_addr;
  logic              out_bram_we;
  logic [ACC_W-1:0]  out_bram_din;
  logic              busy, done, error;
  logic [LW-1:0]     layer_idx;

  layer_sequencer dut (
    .clk(clk), .rst(rst), .go(go),
    .cfg_num_layers(cfg_num_layers), .cfg_out_base(cfg_out_base),
    .sys_start(sys_start), .sys_clear(sys_clear), .sys_busy(sys_busy),
    .sys_acc(sys_acc), .sys_valid(sys_valid),
    .out_bram_addr(out_bram_addr), .out_bram_we(out_bram_we), .out_bram_din(out_bram_din),
    .busy(busy), .done(done), .error(error), .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Output BRAM and handshake monitor.
  int               wr_n = 0, n_start = 0, n_clear = 0;
  logic [AW-1:0]    wr_addr [64];
  logic [ACC_W-1:0] wr_data [64];
  always @(posedge clk) begin
    if (out_bram_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = out_bram_addr;
        wr_data[wr_n] = out_bram_din;
      end
      wr_n++;
    end
    if (sys_start === 1'b1) n_start++;
    if (sys_clear === 1'b1) n_clear++;
  end

  // top_system model: busy rises 3 cycles after start, then plays per-layer
  // valid/acc vectors, then drops busy. Layers past 1 reuse layer 1 vectors.
  logic [0:1][0:1][N-1:0]       m_vld = '0;
  logic [0:1][0:1][N*ACC_W-1:0] m_acc = '0;
  int m_nvec = 0, m_starts = 0, m_sbase = 0;
  bit m_never = 1'b0;
  always begin : sys_model
    int lay;
    @(posedge clk);
    if (sys_start === 1'b1) begin
      lay = m_starts - m_sbase;
      if (lay > 1) lay = 1;
      m_starts++;
      if (!m_never) begin
        repeat (2) @(posedge clk);
        #1 sys_busy = 1'b1;
        for (int k = 0; k < m_nvec; k++) begin
          @(posedge clk);
          #1 sys_valid = m_vld[lay][k];
          sys_acc = m_acc[lay][k];
        end
        @(posedge clk);
        #1 sys_valid = '0;
        sys_acc = '0;
        sys_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic [LW-1:0]                num;
    logic [AW-1:0]                base;
    bit                           go_hold;
    int                           nvec;
    logic [0:1][0:1][N-1:0]       vld;
    logic [0:1][0:1][N*ACC_W-1:0] acc;
    int                           exp_n;
    logic [0:7][ACC_W-1:0]        exp_data;
    bit                           exp_err;
    int                           exp_starts;
    logic [LW-1:0]                exp_layer;
  } row_t;
  row_t rows [4];

  function automatic logic [63:0] outs_vec();
    return {sys_start, sys_clear, out_bram_we, busy, done, error,
            layer_idx, out_bram_addr, out_bram_din};
  endfunction

  initial begin
    int w0, s0, c0, cnt;
    bit got;

    for (int r = 0; r < 4; r++) begin
      rows[r].go_hold = 1'b0; rows[r].vld = '0; rows[r].acc = '0;
      rows[r].exp_data = '0; rows[r].exp_err = 1'b0;
    end
    // Two layers, all lanes valid once per layer.
    rows[0].num = 2; rows[0].base = 8'h10; rows[0].nvec = 1;
    rows[0].vld[0][0] = 4'b1111; rows[0].acc[0][0] = {16'd4, 16'd3, 16'd2, 16'd1};
    rows[0].vld[1][0] = 4'b1111; rows[0].acc[1][0] = {16'd4, 16'd3, 16'd2, 16'd1};
    rows[0].exp_n = 8; rows[0].exp_data = {16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};
    rows[0].exp_starts = 2; rows[0].exp_layer = 2;
    // Address wrap, lane 2 only, last valid wins, other lanes carry junk.
    rows[1].num = 1; rows[1].base = 8'hFE; rows[1].nvec = 2;
    rows[1].vld[0][0] = 4'b0100; rows[1].acc[0][0] = {16'h1111, 16'h7FFF, 16'h2222, 16'h3333};
    rows[1].vld[0][1] = 4'b0100; rows[1].acc[0][1] = {16'h4444, 16'h0005, 16'h5555, 16'h6666};
    rows[1].exp_n = 4; rows[1].exp_data = {16'h0, 16'h0, 16'h0005, 16'h0, 64'h0};
    rows[1].exp_starts = 1; rows[1].exp_layer = 1;
    // Layer 1 must not see layer 0 captures (CLEAR zeroes them).
    rows[2].num = 2; rows[2].base = 8'h40; rows[2].nvec = 1;
    rows[2].vld[0][0] = 4'b0011; rows[2].acc[0][0] = {16'h00EE, 16'h00DD, 16'h0022, 16'h0011};
    rows[2].vld[1][0] = 4'b1000; rows[2].acc[1][0] = {16'h0099, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    rows[2].exp_n = 8; rows[2].exp_data = {16'h11, 16'h22, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h99};
    rows[2].exp_starts = 2; rows[2].exp_layer = 2;
    // go held high (with different cfg) during the run is ignored.
    rows[3].num = 1; rows[3].base = 8'h50; rows[3].nvec = 1; rows[3].go_hold = 1'b1;
    rows[3].vld[0][0] = 4'b1010; rows[3].acc[0][0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    rows[3].exp_n = 4; rows[3].exp_data = {16'h0, 16'h2, 16'h0, 16'h4, 64'h0};
    rows[3].exp_starts = 1; rows[3].exp_layer = 1;

    // Reset and idle.
    rst = 1'b1; tick; tick;
    chk("reset_outputs", outs_vec(), 64'h0);
    rst = 1'b0;
    w0 = wr_n;
    repeat (10) tick;
    chk("idle_outputs", outs_vec(), 64'h0);
    chk("idle_writes", 64'(wr_n - w0), 64'd0);

    // Start timeout with exact phase timing.
    m_never = 1'b1;
    w0 = wr_n;
    cfg_num_layers = 1; cfg_out_base = 8'h00; go = 1'b1;
    tick; go = 1'b0;
    chk("tmo_layerchk_busy", {63'h0, busy}, 64'd1);
    tick;
    chk("tmo_clear_phase", {62'h0, sys_clear, sys_start}, 64'b10);
    tick;
    chk("tmo_start_phase", {62'h0, sys_clear, sys_start}, 64'b01);
    tick;
    repeat (63) tick;
    chk("tmo_wait63", {61'h0, busy, done, error}, 64'b100);
    tick;
    chk("tmo_wait64", {61'h0, busy, done, error}, 64'b011);
    chk("tmo_writes", 64'(wr_n - w0), 64'd0);
    chk("tmo_layer_idx", 64'(layer_idx), 64'd0);
    m_never = 1'b0;

    // Zero layers from DONE: done within 2 cycles, error cleared.
    w0 = wr_n; s0 = n_start;
    cfg_num_layers = 0; go = 1'b1;
    tick; go = 1'b0;
    chk("zero_done_c1", {62'h0, done, error}, 64'b00);
    tick;
    chk("zero_done_c2", {62'h0, done, error}, 64'b10);
    chk("zero_starts", 64'(n_start - s0), 64'd0);
    chk("zero_writes", 64'(wr_n - w0), 64'd0);

    // Table-driven runs.
    for (int r = 0; r < 4; r++) begin
      m_vld = rows[r].vld; m_acc = rows[r].acc; m_nvec = rows[r].nvec;
      m_sbase = m_starts;
      w0 = wr_n; s0 = n_start; c0 = n_clear;
      cfg_num_layers = rows[r].num; cfg_out_base = rows[r].base; go = 1'b1;
      tick; go = 1'b0;
      if (rows[r].go_hold) begin
        cfg_num_layers = 5; cfg_out_base = 8'h00;
      end
      got = 1'b0;
      for (cnt = 0; cnt < 400; cnt++) begin
        if (done === 1'b1) begin got = 1'b1; break; end
        go = rows[r].go_hold && (sys_busy === 1'b1);
        tick;
      end
      go = 1'b0;
      chk($sformatf("row%0d_done", r), {63'h0, got}, 64'd1);
      chk($sformatf("row%0d_busy_err", r), {62'h0, busy, error}, {62'h0, 1'b0, rows[r].exp_err});
      chk($sformatf("row%0d_layer_idx", r), 64'(layer_idx), 64'(rows[r].exp_layer));
      chk($sformatf("row%0d_starts", r), 64'(n_start - s0), 64'(rows[r].exp_starts));
      chk($sformatf("row%0d_clears", r), 64'(n_clear - c0), 64'(rows[r].exp_starts));
      chk($sformatf("row%0d_nwrites", r), 64'(wr_n - w0), 64'(rows[r].exp_n));
      for (int i = 0; i < rows[r].exp_n && i < 8; i++) begin
        logic [AW-1:0] ea;
        ea = rows[r].base + AW'(i);
        chk($sformatf("row%0d_w%0d_addr", r, i), 64'(wr_addr[w0 + i]), 64'(ea));
        chk($sformatf("row%0d_w%0d_data", r, i), 64'(wr_data[w0 + i]), 64'(rows[r].exp_data[i]));
      end
      tick;
    end

    // Reset during DRAIN at j=1.
    m_vld = '0; m_acc = '0;
    m_vld[0][0] = 4'b1111; m_acc[0][0] = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    m_nvec = 1; m_sbase = m_starts;
    w0 = wr_n;
    cfg_num_layers = 1; cfg_out_base = 8'h20; go = 1'b1;
    tick; go = 1'b0;
    got = 1'b0;
    for (cnt = 0; cnt < 100; cnt++) begin
      if (out_bram_we === 1'b1) begin got = 1'b1; break; end
      tick;
    end
    chk("rstd_drain_seen", {63'h0, got}, 64'd1);
    chk("rstd_j0", {40'h0, out_bram_addr, out_bram_din}, {40'h0, 8'h20, 16'h000A});
    tick;
    chk("rstd_j1", {40'h0, out_bram_addr, out_bram_din}, {40'h0, 8'h21, 16'h000B});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstd_outputs", outs_vec(), 64'h0);
    repeat (6) tick;
    chk("rstd_writes", 64'(wr_n - w0), 64'd2);
    chk("rstd_idle_outputs", outs_vec(), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
